data_mem_bank: RTL and testbench

Parametrised successor to the MIPS data memory. Provides a word-addressed RAM with:
- byte-lane write strobes
- a registered read port with write-first forwarding
- a hardware clear engine that zeroes the array one word per cycle after reset or on request

Sits between the MEM pipeline stage and the array; the pipeline stalls on busy.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_clear_fsm.sv | 59 +++++
 rtl/data_mem_bank.sv | 88 ++++++++
 tb/tb_data_mem_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory bank: clear-engine states and byte-lane merge.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int WORD_W    = 32;
    localparam int LANES     = WORD_W / 8;
    // Merge is written once at the widest supported word; callers zero-extend and truncate.
    localparam int MAX_W     = 256;
    localparam int MAX_LANES = MAX_W / 8;

    function automatic logic [MAX_W-1:0] merge_lanes(
        input logic [MAX_W-1:0]     old_w,
        input logic [MAX_W-1:0]     new_w,
        input logic [MAX_LANES-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Clear engine: walks a pointer over every word after reset or on request, one word per cycle.
// busy is high for exactly MEM_DEPTH cycles; clear_req is ignored while already clearing.
module mem_clear_fsm
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear_req,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ptr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        o_busy      = 1'b0;
        case (r_state)
            CLEAR: begin
                o_busy = 1'b1;
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = READY;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            READY: begin
                if (i_clear_req) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/data_mem_bank.sv
// Word-addressed RAM with byte strobes, registered write-first read (1-cycle latency) and a clear engine.
// No backpressure while ready; all accesses are dropped while busy, and the pipeline is expected to stall.
module data_mem_bank
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int WIDTH     = WORD_W,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [WIDTH/8-1:0]   wr_be,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 err_oob
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    logic [WIDTH-1:0]  r_mem [MEM_DEPTH];
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;
    logic              r_err_oob;

    logic              w_busy;
    logic [ADDR_W-1:0] w_clr_ptr;
    logic              w_rd_in, w_wr_in, w_rd_oob, w_wr_oob, w_fwd;
    logic [WIDTH-1:0]  w_wr_merged;
    logic [WIDTH-1:0]  w_rd_word;

    mem_clear_fsm #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_clear_fsm (
        .i_clk       (clk),
        .i_rst_n     (reset_b),
        .i_clear_req (clear_req),
        .o_busy      (w_busy),
        .o_ptr       (w_clr_ptr)
    );

    assign w_rd_in  = !w_busy && rd_en && ({1'b0, rd_addr} < DEPTH_LIM);
    assign w_wr_in  = !w_busy && wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
    assign w_rd_oob = !w_busy && rd_en && !({1'b0, rd_addr} < DEPTH_LIM);
    assign w_wr_oob = !w_busy && wr_en && !({1'b0, wr_addr} < DEPTH_LIM);
    assign w_fwd    = w_rd_in && w_wr_in && (rd_addr == wr_addr);

    // One merge serves both the array write and the write-first forward, since forwarding implies equal addresses.
    assign w_wr_merged = WIDTH'(merge_lanes(MAX_W'(r_mem[wr_addr]), MAX_W'(wr_data), MAX_LANES'(wr_be)));
    assign w_rd_word   = w_fwd ? w_wr_merged : r_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[w_clr_ptr] <= '0;
        end else if (w_wr_in) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err_oob  <= 1'b0;
        end else begin
            if (w_rd_in) begin
                r_rd_data <= w_rd_word;
            end else if (w_rd_oob) begin
                r_rd_data <= '0;
            end
            r_rd_valid <= w_rd_in || w_rd_oob;
            r_err_oob  <= w_rd_oob || w_wr_oob;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err_oob  = r_err_oob;
    assign busy     = w_busy;

endmodule

// File: tb/tb_data_mem_bank.sv
// Self-checking bench for data_mem_bank: directed steps plus a randomized phase against an array model.
module tb_data_mem_bank;

    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam int MAXC  = 5000;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        rd_en, wr_en, clear_req;
    logic [9:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [31:0] rd_data;
    logic        rd_valid, busy, err_oob;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_data;
    int          n;

    always #5 clk = ~clk;

    data_mem_bank #(.MEM_DEPTH(DEPTH), .WIDTH(32), .ADDR_W(AW)) dut (
        .clk(clk), .reset_b(reset_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clear_req(clear_req), .busy(busy), .err_oob(err_oob)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic logic [31:0] merge_m(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (d & mask);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 0; wr_en = 0; clear_req = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic op(input logic r, input int ra, input logic w, input int wa,
                      input logic [31:0] wd, input logic [3:0] be);
        rd_en = r; rd_addr = 10'(ra);
        wr_en = w; wr_addr = 10'(wa); wr_data = wd; wr_be = be;
        tick();
        idle();
    endtask

    task automatic count_busy(input string tag);
        n = 0;
        while (busy === 1'b1 && n < MAXC) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        idle();
        reset_b = 1'b0;
        tick(); tick();
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_err_oob", 32'(err_oob), 32'h0);

        // Release reset and measure the clear, with accesses presented that must be ignored.
        reset_b = 1'b1;
        rd_en = 1; rd_addr = 10'd1010; wr_en = 1; wr_addr = 10'd1; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        tick();
        chk("busy_rd_valid", 32'(rd_valid), 32'h0);
        chk("busy_err_oob", 32'(err_oob), 32'h0);
        idle();
        n = 1;
        while (busy === 1'b1 && n < MAXC) begin
            tick();
            n++;
        end
        chk("reset_clear_len", 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        op(1, 0, 0, 0, 0, 0);
        chk("t1_rd0_valid", 32'(rd_valid), 32'h1);
        chk("t1_rd0_data", rd_data, 32'h0);
        op(1, 5, 0, 0, 0, 0);
        chk("t1_rd5_data", rd_data, 32'h0);
        op(1, 1, 0, 0, 0, 0);
        chk("t1_rd1_ignored_wr", rd_data, 32'h0);
        op(1, DEPTH - 1, 0, 0, 0, 0);
        chk("t1_rdlast_valid", 32'(rd_valid), 32'h1);
        chk("t1_rdlast_data", rd_data, 32'h0);
        tick();
        chk("t1_valid_pulse", 32'(rd_valid), 32'h0);

        // Randomized traffic against the array model.
        exp_data = rd_data;
        for (int c = 0; c < 400; c++) begin
            logic rin, win;
            rd_en   = 1'($urandom_range(0, 1));
            wr_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 15));
            wr_addr = ($urandom_range(0, 2) == 0) ? rd_addr :
                      (($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 15)));
            wr_data = $urandom;
            wr_be   = 4'($urandom_range(0, 15));
            rin = rd_en && (int'(rd_addr) < DEPTH);
            win = wr_en && (int'(wr_addr) < DEPTH);
            if (rd_en) begin
                if (!rin) exp_data = 32'h0;
                else if (win && wr_addr == rd_addr) exp_data = merge_m(model[rd_addr], wr_data, wr_be);
                else exp_data = model[rd_addr];
            end
            tick();
            chk("rnd_rd_valid", 32'(rd_valid), 32'(rd_en));
            chk("rnd_rd_data", rd_data, exp_data);
            chk("rnd_err_oob", 32'(err_oob), 32'((rd_en && !rin) || (wr_en && !win)));
            if (win) model[wr_addr] = merge_m(model[wr_addr], wr_data, wr_be);
        end
        idle();
        tick();

        op(0, 0, 1, 12, 32'hDEADBEEF, 4'b1111);
        op(0, 0, 1, 12, 32'h000000AA, 4'b0001);
        op(1, 12, 0, 0, 0, 0);
        chk("t2_partial_write", rd_data, 32'hDEADBEAA);
        op(0, 0, 1, 12, 32'h12345678, 4'b0000);
        op(1, 12, 0, 0, 0, 0);
        chk("t2_be_zero_noop", rd_data, 32'hDEADBEAA);

        op(0, 0, 1, 7, 32'hAAAAAAAA, 4'b1111);
        op(1, 7, 1, 7, 32'h11223344, 4'b1100);
        chk("t3_fwd_valid", 32'(rd_valid), 32'h1);
        chk("t3_fwd_data", rd_data, 32'h1122AAAA);
        op(1, 7, 0, 0, 0, 0);
        chk("t3_stored", rd_data, 32'h1122AAAA);

        op(0, 0, 1, 999, 32'h99999999, 4'b1111);
        chk("t4_rd_data_hold", rd_data, 32'h1122AAAA);
        chk("t4_no_err", 32'(err_oob), 32'h0);
        op(1, 1000, 1, 998, 32'hCAFE0001, 4'b1111);
        chk("t4_oob_rd_data", rd_data, 32'h0);
        chk("t4_oob_rd_valid", 32'(rd_valid), 32'h1);
        chk("t4_oob_rd_err", 32'(err_oob), 32'h1);
        op(0, 0, 1, 1001, 32'h12345678, 4'b1111);
        chk("t4_oob_wr_err", 32'(err_oob), 32'h1);
        chk("t4_oob_wr_novalid", 32'(rd_valid), 32'h0);
        op(1, 999, 0, 0, 0, 0);
        chk("t4_err_pulse", 32'(err_oob), 32'h0);
        chk("t4_999_unchanged", rd_data, 32'h99999999);
        op(1, 998, 0, 0, 0, 0);
        chk("t4_other_port_wr", rd_data, 32'hCAFE0001);

        // clear_req with a same-cycle read: the read is still serviced.
        op(0, 0, 1, 3, 32'h5, 4'b1111);
        rd_en = 1; rd_addr = 10'd3; clear_req = 1;
        tick();
        idle();
        chk("t5_same_cycle_rd", rd_data, 32'h5);
        chk("t5_busy_rises", 32'(busy), 32'h1);
        n = 0;
        while (busy === 1'b1 && n < MAXC) begin
            if (n == 10) begin
                wr_en = 1; wr_addr = 10'd3; wr_data = 32'h77; wr_be = 4'hF;
                rd_en = 1; rd_addr = 10'd3; clear_req = 1;
            end
            tick();
            if (n == 10) begin
                chk("t5_busy_rd_ignored", 32'(rd_valid), 32'h0);
                idle();
            end
            n++;
        end
        chk("t5_clear_len", 32'(n), 32'(DEPTH));
        op(1, 3, 0, 0, 0, 0);
        chk("t5_addr3_cleared", rd_data, 32'h0);
        op(1, 999, 0, 0, 0, 0);
        chk("t5_addr999_cleared", rd_data, 32'h0);

        op(0, 0, 1, 20, 32'h12345678, 4'b1111);
        op(1, 20, 0, 0, 0, 0);
        chk("t6_pre_data", rd_data, 32'h12345678);
        clear_req = 1;
        tick();
        idle();
        for (int i = 0; i < 500; i++) tick();
        reset_b = 1'b0;
        #1;
        chk("t6_rst_rd_data", rd_data, 32'h0);
        chk("t6_rst_rd_valid", 32'(rd_valid), 32'h0);
        tick();
        chk("t6_rst_busy", 32'(busy), 32'h1);
        reset_b = 1'b1;
        count_busy("t6_clear_len");
        op(1, 20, 0, 0, 0, 0);
        chk("t6_addr20_cleared", rd_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
